// File: rtl/tiler_pkg.sv
// Shared types and constants for the LiDAR tile index stage.
// Holds lane-slice widths, the grid-edge index and the per-beat config bundle.
package tiler_pkg;

    localparam int PKG_COORD_W = 16;
    localparam int PKG_IDX_W   = 4;
    localparam int PKG_SHIFT_W = 4;

    // Bits per lane in the packed coordinate and index buses
    localparam int LANE_COORD_W = 2 * PKG_COORD_W;
    localparam int LANE_IDX_W   = 2 * PKG_IDX_W;

    localparam logic [PKG_IDX_W-1:0] IDX_MAX = '1;

    typedef struct packed {
        logic signed [PKG_COORD_W-1:0] origin_x;
        logic signed [PKG_COORD_W-1:0] origin_y;
        logic [PKG_SHIFT_W-1:0]        shift;
        logic                          clamp;
    } cfg_t;

endpackage

// File: rtl/tile_axis_quantizer.sv
// Combinational per-axis quantizer: q = d >>> shift, range check, clamp.
// Ports: d (signed offset), shift, clamp -> idx (tile index), oor (out of range).
module tile_axis_quantizer #(
    parameter int D_W     = 17,
    parameter int SHIFT_W = 4,
    parameter int IDX_W   = 4
) (
    input  logic signed [D_W-1:0] d,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  clamp,
    output logic [IDX_W-1:0]      idx,
    output logic                  oor
);

    logic signed [D_W-1:0] q;
    logic                  neg;
    logic                  over;

    // Arithmetic shift fills with the sign, so huge shifts yield 0 or -1
    assign q    = d >>> shift;
    assign neg  = d[D_W-1];
    assign over = !neg && (q[D_W-1:IDX_W] != '0);
    assign oor  = neg || over;

    always_comb begin
        idx = q[IDX_W-1:0];
        if (oor) begin
            idx = (clamp && over) ? '1 : '0;
        end
    end

endmodule

// File: rtl/tile_index_mapper.sv
// Two-stage tile index pipeline: S1 subtracts the grid origin, S2 quantizes.
// Ports: in_* beat + cfg_* (sampled on accept), out_* beat, oor_count stats.
module tile_index_mapper
    import tiler_pkg::*;
#(
    parameter int NUM_PTS = 4,
    parameter int COORD_W = PKG_COORD_W,
    parameter int IDX_W   = PKG_IDX_W,
    parameter int SHIFT_W = PKG_SHIFT_W,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_PTS*2*COORD_W-1:0]  in_coords,
    input  logic [NUM_PTS-1:0]            in_lane_mask,
    input  logic signed [COORD_W-1:0]     cfg_origin_x,
    input  logic signed [COORD_W-1:0]     cfg_origin_y,
    input  logic [SHIFT_W-1:0]            cfg_shift,
    input  logic                          cfg_clamp,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_PTS*2*IDX_W-1:0]    out_tile_idx,
    output logic [NUM_PTS-1:0]            out_lane_mask,
    output logic [NUM_PTS-1:0]            out_oor,
    input  logic                          stats_clear,
    output logic [CNT_W-1:0]              oor_count
);

    localparam int D_W   = COORD_W + 1;
    localparam int LCW   = 2 * COORD_W;
    localparam int LIW   = 2 * IDX_W;
    localparam int POP_W = $clog2(NUM_PTS + 1);

    cfg_t                  cfg_in;
    logic                  s2_load;
    logic signed [D_W-1:0] dx [NUM_PTS];
    logic signed [D_W-1:0] dy [NUM_PTS];

    logic                  s1_valid;
    logic signed [D_W-1:0] s1_dx [NUM_PTS];
    logic signed [D_W-1:0] s1_dy [NUM_PTS];
    logic [NUM_PTS-1:0]    s1_mask;
    logic [SHIFT_W-1:0]    s1_shift;
    logic                  s1_clamp;

    logic [LIW-1:0]              lane_idx [NUM_PTS];
    logic [NUM_PTS-1:0]          nxt_mask;
    logic [NUM_PTS-1:0]          nxt_oor;
    logic [NUM_PTS*2*IDX_W-1:0]  nxt_idx;
    logic [POP_W-1:0]            oor_pop;
    logic [CNT_W:0]              cnt_sum;

    assign cfg_in = '{
        origin_x: cfg_origin_x,
        origin_y: cfg_origin_y,
        shift:    cfg_shift,
        clamp:    cfg_clamp
    };

    // No skid buffer: in_ready follows out_ready combinationally
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    for (genvar i = 0; i < NUM_PTS; i++) begin : g_s1
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        assign x = in_coords[i*LCW +: COORD_W];
        assign y = in_coords[i*LCW+COORD_W +: COORD_W];
        // One extra bit keeps the difference exact
        assign dx[i] = $signed({x[COORD_W-1], x})
                     - $signed({cfg_in.origin_x[COORD_W-1], cfg_in.origin_x});
        assign dy[i] = $signed({y[COORD_W-1], y})
                     - $signed({cfg_in.origin_y[COORD_W-1], cfg_in.origin_y});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mask  <= '0;
            s1_shift <= '0;
            s1_clamp <= 1'b0;
            for (int i = 0; i < NUM_PTS; i++) begin
                s1_dx[i] <= '0;
                s1_dy[i] <= '0;
            end
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mask  <= in_lane_mask;
                s1_shift <= cfg_in.shift;
                s1_clamp <= cfg_in.clamp;
                for (int i = 0; i < NUM_PTS; i++) begin
                    s1_dx[i] <= dx[i];
                    s1_dy[i] <= dy[i];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_PTS; i++) begin : g_s2
        logic [IDX_W-1:0] ix;
        logic [IDX_W-1:0] iy;
        logic             ox;
        logic             oy;
        logic             lane_oor;
        logic             keep;

        tile_axis_quantizer #(
            .D_W     (D_W),
            .SHIFT_W (SHIFT_W),
            .IDX_W   (IDX_W)
        ) u_qx (
            .d     (s1_dx[i]),
            .shift (s1_shift),
            .clamp (s1_clamp),
            .idx   (ix),
            .oor   (ox)
        );

        tile_axis_quantizer #(
            .D_W     (D_W),
            .SHIFT_W (SHIFT_W),
            .IDX_W   (IDX_W)
        ) u_qy (
            .d     (s1_dy[i]),
            .shift (s1_shift),
            .clamp (s1_clamp),
            .idx   (iy),
            .oor   (oy)
        );

        // Without clamping an OOR lane is dropped: mask cleared, both idx 0
        assign lane_oor    = s1_mask[i] & (ox | oy);
        assign keep        = s1_mask[i] & (s1_clamp | ~lane_oor);
        assign nxt_oor[i]  = lane_oor;
        assign nxt_mask[i] = keep;
        assign lane_idx[i] = keep ? {iy, ix} : '0;
    end

    always_comb begin
        nxt_idx = '0;
        for (int i = 0; i < NUM_PTS; i++) begin
            nxt_idx[i*LIW +: LIW] = lane_idx[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_tile_idx  <= '0;
            out_lane_mask <= '0;
            out_oor       <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_tile_idx  <= nxt_idx;
                out_lane_mask <= nxt_mask;
                out_oor       <= nxt_oor;
            end
        end
    end

    always_comb begin
        oor_pop = '0;
        for (int i = 0; i < NUM_PTS; i++) begin
            oor_pop = oor_pop + POP_W'(out_oor[i]);
        end
    end

    assign cnt_sum = {1'b0, oor_count} + (CNT_W+1)'(oor_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oor_count <= '0;
        end else if (stats_clear) begin
            oor_count <= '0;
        end else if (out_valid && out_ready) begin
            oor_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: doc/tile_index_mapper.md
Name: tile_index_mapper

Overview:
- Parametrised successor to the fixed 4-point tile index stage in the LiDAR Point Cloud Tiler.
- Accepts a beat of NUM_PTS normalised (X,Y) points, subtracts a runtime tile-grid origin and divides by a runtime power-of-two tile size.
- Range-checks each point and emits per-point tile indices with out-of-range (OOR) flags.
- Two-stage valid/ready pipeline with full backpressure, plus a saturating OOR statistics counter. Sits between the coordinate normaliser and the tile binning/buffer stage.

Parameters:
- NUM_PTS, 4, points (lanes) per beat.
- COORD_W, 16, width of each signed X or Y coordinate.
- IDX_W, 4, width of each tile index (grid is 2^IDX_W by 2^IDX_W).
- SHIFT_W, 4, width of the tile-size shift config.
- CNT_W, 16, width of the OOR statistics counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_coords  in  NUM_PTS*2*COORD_W  lane i: X at [i*2*COORD_W +: COORD_W], Y at [i*2*COORD_W+COORD_W +: COORD_W], both signed.
- in_lane_mask  in  NUM_PTS  lane i carries a real point when 1.
- cfg_origin_x  in  COORD_W  signed grid origin X.
- cfg_origin_y  in  COORD_W  signed grid origin Y.
- cfg_shift  in  SHIFT_W  tile size = 2^cfg_shift coordinate units.
- cfg_clamp  in  1  1 = clamp OOR points to the grid edge; 0 = flag and drop them.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_tile_idx  out  NUM_PTS*2*IDX_W  lane i: X idx at [i*2*IDX_W +: IDX_W], Y idx at [i*2*IDX_W+IDX_W +: IDX_W].
- out_lane_mask  out  NUM_PTS  surviving lanes.
- out_oor  out  NUM_PTS  per-lane out-of-range flag.
- stats_clear  in  1  synchronous clear of oor_count.
- oor_count  out  CNT_W  saturating count of OOR points delivered.

Behaviour:
- Reset (async, immediate): out_valid=0, out_tile_idx=0, out_lane_mask=0, out_oor=0, oor_count=0, both stage valids=0. in_ready=1 on the first cycle after reset deasserts.
- Pipeline:
  - S1 registers dx = x - origin_x and dy = y - origin_y at COORD_W+1 signed width (no overflow), plus the mask, shift and clamp bits of that beat.
  - S2 (the output register) computes the indices.
  - cfg_* values are sampled at input acceptance and carried with the beat, so a config change never affects beats already in flight.
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput: 1 beat per cycle.
- Handshake:
  - S2 loads when !out_valid || out_ready. S1 advances under the same condition. in_ready = !s1_valid || s2_load.
  - in_ready is combinational from out_ready (no skid buffer); this is permitted.
  - While out_valid && !out_ready, all out_* signals are held stable.
- Per axis, per lane:
  - q = d >>> cfg_shift (arithmetic shift).
  - OOR if d<0 or q > 2^IDX_W-1. Lane OOR = X OOR or Y OOR, and only when the mask bit is 1. Masked-off lanes: oor=0, idx=0.
  - cfg_clamp=1: negative d gives idx 0; overflow gives 2^IDX_W-1; the mask bit is kept.
  - cfg_clamp=0: an OOR lane outputs idx 0 on both axes and its out_lane_mask bit is cleared.
  - cfg_shift >= COORD_W+1: q becomes 0 for d>=0 and -1 for d<0. This is legal.
- Beat with in_lane_mask=0: passes through as a valid beat with mask 0. It is not dropped.
- oor_count:
  - On each output handshake, add popcount(out_oor). Saturate at 2^CNT_W-1.
  - stats_clear takes priority; an increment in the same cycle is discarded.
- Reset mid-operation: in-flight beats are discarded and no partial beat is emitted.

Decomposition:
- Shared package tiler_pkg: lane-slice helpers/localparams (LANE_COORD_W = 2*COORD_W, LANE_IDX_W = 2*IDX_W), IDX_MAX constant, cfg struct/typedef {origin_x, origin_y, shift, clamp}.
- One sub-module, tile_axis_quantizer: combinational per-axis shift, range check and clamp (inputs d, shift, clamp; outputs idx, oor). Instantiate 2*NUM_PTS copies in S2.

Test Plan:
- Defaults with origin 0, shift 6, clamp 0: lane0 X=0x0140, Y=0x0310 -> idx X=5, Y=12, oor=0, out_valid exactly 2 cycles after the handshake.
- X=0x0400 (q=16), shift 6: clamp=0 -> idx 0/0, oor[0]=1, mask[0]=0, oor_count=1. Clamp=1 -> idx X=15, mask[0]=1.
- origin_x=0x0100, X=0x00C0 (d<0): clamp=1 -> idx X=0, oor=1. Same X with lane masked off -> oor=0, oor_count unchanged.
- Back-to-back beats A,B,C with out_ready low for 3 cycles after A appears: A is held stable and in_ready falls once S1 holds B. After release, A,B,C emerge in order with no loss or duplication.
- Change cfg_shift from 6 to 4 while a beat is in S1: the in-flight beat uses shift 6 and the next beat uses shift 4.
- Preload oor_count to 0xFFFE, deliver a beat with 4 OOR lanes -> 0xFFFF. Assert stats_clear in the same cycle as an OOR beat -> 0. Assert reset mid-stall -> out_valid=0 at once and oor_count=0.
